pipeline_output_fifo: RTL and testbench

PIPELINE_OUTPUT_FIFO -- requirements
Module: pipeline_output_fifo

---
 rtl/pipeline_output_fifo.sv | 99 +++++++++
 tb/tb_pipeline_output_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_output_fifo.sv
// First-word fall-through output FIFO placed after a register pipeline.
// Optional stall counter enabled by defining PIPELINE_OUTPUT_FIFO_STATS_EN.
module pipeline_output_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     datain,
    input  logic                      datain_valid,
    output logic                      datain_ready,
    output logic [DATA_WIDTH-1:0]     dataout,
    output logic                      dataout_valid,
    input  logic                      dataout_ready,
    output logic [$clog2(DEPTH):0]    count
`ifdef PIPELINE_OUTPUT_FIFO_STATS_EN
    ,
    output logic [15:0]               stall_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Handshake: a word moves on a rising edge only when valid and ready are
    // both 1 on that side; ready/valid are pure functions of registered count.

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  push, pop;

    assign datain_ready  = (count_q != FULL_CNT);
    assign dataout_valid = (count_q != '0);
    assign dataout       = dataout_valid ? mem_q[rd_ptr_q] : '0;
    assign count         = count_q;

    assign push = datain_valid && datain_ready;
    assign pop  = dataout_valid && dataout_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= datain;
        end
    end

`ifdef PIPELINE_OUTPUT_FIFO_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (datain_valid && !datain_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_pipeline_output_fifo.sv
// Directed self-checking bench for pipeline_output_fifo (DEPTH=4, 16-bit).
// Define PIPELINE_OUTPUT_FIFO_STATS_EN to also exercise stall_count.
module tb_pipeline_output_fifo;

    logic        clk;
    logic        rst;
    logic [15:0] datain;
    logic        datain_valid;
    logic        datain_ready;
    logic [15:0] dataout;
    logic        dataout_valid;
    logic        dataout_ready;
    logic [2:0]  count;
`ifdef PIPELINE_OUTPUT_FIFO_STATS_EN
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    pipeline_output_fifo #(.DATA_WIDTH(16), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .datain        (datain),
        .datain_valid  (datain_valid),
        .datain_ready  (datain_ready),
        .dataout       (dataout),
        .dataout_valid (dataout_valid),
        .dataout_ready (dataout_ready),
        .count         (count)
`ifdef PIPELINE_OUTPUT_FIFO_STATS_EN
        ,
        .stall_count   (stall_count)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        if (obs !== expd) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic do_reset(input int cycles);
        rst = 1'b1;
        datain_valid = 1'b1;
        dataout_ready = 1'b1;
        datain = 16'hDEAD;
        for (int i = 0; i < cycles; i++) tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_dout_valid", 32'(dataout_valid), 32'd0);
        check("rst_din_ready", 32'(datain_ready), 32'd1);
        check("rst_dataout", 32'(dataout), 32'h0000);
        rst = 1'b0;
        datain_valid = 1'b0;
        dataout_ready = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_word(input logic [15:0] w);
        datain = w;
        datain_valid = 1'b1;
        dataout_ready = 1'b0;
        exp_q.push_back(w);
        tick();
        datain_valid = 1'b0;
        datain = 16'hBEEF;
    endtask

    task automatic pop_word(input string tag);
        logic [15:0] e;
        e = exp_q.pop_front();
        check({tag, "_valid"}, 32'(dataout_valid), 32'd1);
        check({tag, "_data"}, 32'(dataout), 32'(e));
        datain_valid = 1'b0;
        dataout_ready = 1'b1;
        tick();
        dataout_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        datain = '0;
        datain_valid = 1'b0;
        dataout_ready = 1'b0;

        do_reset(2);

        // fill, 1-cycle fall-through latency on first word
        push_word(16'h1111);
        check("fill1_count", 32'(count), 32'd1);
        check("fill1_dataout", 32'(dataout), 32'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        push_word(16'h4444);
        check("full_count", 32'(count), 32'd4);
        check("full_din_ready", 32'(datain_ready), 32'd0);
        check("full_dataout", 32'(dataout), 32'h1111);
        // refused push: not recorded in the model
        datain = 16'h5555;
        datain_valid = 1'b1;
        tick();
        datain_valid = 1'b0;
        check("refused_count", 32'(count), 32'd4);
        check("refused_dataout", 32'(dataout), 32'h1111);

        // drain with pointer wrap
        pop_word("drain0");
        pop_word("drain1");
        check("half_count", 32'(count), 32'd2);
        push_word(16'hAAAA);
        push_word(16'hBBBB);
        check("wrap_full_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) pop_word($sformatf("drain%0d", i + 2));
        check("drained_count", 32'(count), 32'd0);
        check("drained_valid", 32'(dataout_valid), 32'd0);
        check("drained_dataout", 32'(dataout), 32'h0000);
        check("drained_queue", 32'(exp_q.size()), 32'd0);

        // pop on empty is ignored
        dataout_ready = 1'b1;
        datain = 16'h7777;
        tick();
        dataout_ready = 1'b0;
        check("empty_pop_count", 32'(count), 32'd0);
        check("empty_pop_dataout", 32'(dataout), 32'h0000);

        // full with simultaneous pop: pop taken, push refused
        push_word(16'h0101);
        push_word(16'h0202);
        push_word(16'h0303);
        push_word(16'h0404);
        datain = 16'h5555;
        datain_valid = 1'b1;
        dataout_ready = 1'b1;
        void'(exp_q.pop_front());
        tick();
        datain_valid = 1'b0;
        dataout_ready = 1'b0;
        check("fullpop_count", 32'(count), 32'd3);
        check("fullpop_din_ready", 32'(datain_ready), 32'd1);
        check("fullpop_dataout", 32'(dataout), 32'h0202);
        for (int i = 0; i < 3; i++) pop_word($sformatf("fp%0d", i));
        check("fp_end_count", 32'(count), 32'd0);

        // streaming: count holds at 1, each word out one cycle after push
        datain_valid = 1'b1;
        dataout_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [15:0] w;
            w = 16'($urandom_range(0, 16'hFFFF));
            datain = w;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            exp_q.push_back(w);
            tick();
            check($sformatf("stream%0d_count", i), 32'(count), 32'd1);
            check($sformatf("stream%0d_data", i), 32'(dataout), 32'(exp_q[0]));
        end
        datain_valid = 1'b0;
        dataout_ready = 1'b0;
        tick();
        check("stream_hold_count", 32'(count), 32'd1);

        // mid-operation reset discards contents, same-cycle push/pop ignored
        do_reset(1);

`ifdef PIPELINE_OUTPUT_FIFO_STATS_EN
        check("stats_rst", 32'(stall_count), 32'd0);
        push_word(16'h1234);
        push_word(16'h2345);
        push_word(16'h3456);
        push_word(16'h4567);
        check("stats_fill", 32'(stall_count), 32'd0);
        datain = 16'h9999;
        datain_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        datain_valid = 1'b0;
        check("stats_stall10", 32'(stall_count), 32'd10);
        check("stats_full_count", 32'(count), 32'd4);
        do_reset(1);
        check("stats_cleared", 32'(stall_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
